// File: rtl/sparse_seg_gen_if.sv
// Request/result bundle for the sparse segment generator.
// The master drives the request side; the generator (slave) returns status and the segment.
interface sparse_seg_gen_if;
  logic        start;
  logic [4:0]  count;
  logic        load_seed;
  logic [15:0] seed;
  logic        busy;
  logic        done;
  logic [15:0] seg_out;

  modport master (
    output start, count, load_seed, seed,
    input  busy, done, seg_out
  );

  modport slave (
    input  start, count, load_seed, seed,
    output busy, done, seg_out
  );
endinterface

// File: rtl/sparse_seg_gen.sv
// Builds one 16-bit segment with exactly min(count,16) ones, one bit per GEN cycle.
// Positions come from an LFSR nibble; a rotate/priority search skips bits already set.
module sparse_seg_gen #(
  parameter logic [15:0] RESET_SEED = 16'hACE1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  sparse_seg_gen_if.slave  io_seg
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_GEN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]  r_state;
  logic [15:0] r_lfsr;
  logic [15:0] r_seg;
  logic [4:0]  r_remaining;

  logic [4:0]  w_k;
  logic [15:0] w_seed_eff;
  logic [3:0]  w_p;
  logic [15:0] w_rot;
  logic [3:0]  w_ofs;
  logic        w_found;
  logic [3:0]  w_pos;
  logic [15:0] w_place;
  logic [15:0] w_lfsr_next;

  assign w_k        = (io_seg.count > 5'd16) ? 5'd16 : io_seg.count;
  assign w_seed_eff = (io_seg.seed == 16'h0000) ? RESET_SEED : io_seg.seed;
  assign w_p        = r_lfsr[3:0];

  // w_rot[j] is seg bit (p+j) mod 16, so the lowest clear bit of w_rot is the first free slot.
  assign w_rot = (r_seg >> w_p) | (r_seg << (5'd16 - {1'b0, w_p}));

  always_comb begin
    w_ofs   = 4'd0;
    w_found = 1'b0;
    for (int j = 0; j < 16; j++) begin
      if (!w_found && !w_rot[j]) begin
        w_ofs   = 4'(j);
        w_found = 1'b1;
      end
    end
  end

  assign w_pos       = w_p + w_ofs;
  assign w_place     = 16'h0001 << w_pos;
  assign w_lfsr_next = {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_lfsr      <= RESET_SEED;
      r_seg       <= 16'h0000;
      r_remaining <= 5'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (io_seg.load_seed) begin
            r_lfsr <= w_seed_eff;
          end
          if (io_seg.start) begin
            r_remaining <= w_k;
            r_seg       <= 16'h0000;
            r_state     <= (w_k == 5'd0) ? S_DONE : S_GEN;
          end
        end
        S_GEN: begin
          r_seg       <= r_seg | w_place;
          r_remaining <= r_remaining - 5'd1;
          r_lfsr      <= w_lfsr_next;
          if (r_remaining == 5'd1) begin
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign io_seg.busy    = (r_state == S_GEN) || (r_state == S_DONE);
  assign io_seg.done    = (r_state == S_DONE);
  assign io_seg.seg_out = r_seg;

endmodule

// File: tb/tb_sparse_seg_gen.sv
// Directed and swept checks of sparse_seg_gen: results, latency, saturation, seeding, protocol.
module tb_sparse_seg_gen;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sparse_seg_gen_if bus ();

  sparse_seg_gen #(.RESET_SEED(16'hACE1)) dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .io_seg (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  logic [15:0] m_lfsr;

  // Reference placement: walk upward from the LFSR nibble until a clear bit is found.
  task automatic model_run(input int k, output logic [15:0] seg);
    int kk;
    int pos;
    kk  = (k > 16) ? 16 : k;
    seg = 16'h0000;
    for (int i = 0; i < kk; i++) begin
      pos = int'(m_lfsr[3:0]);
      while (seg[pos]) pos = (pos + 1) % 16;
      seg[pos] = 1'b1;
      m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    end
  endtask

  task automatic start_op(input int k, input logic ld, input logic [15:0] sd);
    bus.count     = 5'(k);
    bus.start     = 1'b1;
    bus.load_seed = ld;
    bus.seed      = sd;
    @(posedge clk);
    @(negedge clk);
    bus.start     = 1'b0;
    bus.load_seed = 1'b0;
    if (ld) m_lfsr = (sd == 16'h0000) ? 16'hACE1 : sd;
  endtask

  task automatic wait_done(input int already, output int lat);
    lat = already;
    while (!bus.done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    if (!bus.done) begin
      n_tests++;
      n_fail++;
      $display("FAIL done_timeout: got no done after %0d cycles, want done", lat);
    end
  endtask

  task automatic run_op(input int k, input logic ld, input logic [15:0] sd,
                        output logic [15:0] seg, output int lat,
                        output logic after_busy, output logic after_done);
    start_op(k, ld, sd);
    wait_done(1, lat);
    seg = bus.seg_out;
    @(negedge clk);
    after_busy = bus.busy;
    after_done = bus.done;
  endtask

  task automatic test_reset;
    bus.start     = 1'b0;
    bus.load_seed = 1'b0;
    bus.count     = 5'd0;
    bus.seed      = 16'h0000;
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    n_tests++;
    if (bus.busy !== 1'b0) begin
      n_fail++; $display("FAIL reset_busy: got %b want 0", bus.busy);
    end
    n_tests++;
    if (bus.done !== 1'b0) begin
      n_fail++; $display("FAIL reset_done: got %b want 0", bus.done);
    end
    n_tests++;
    if (bus.seg_out !== 16'h0000) begin
      n_fail++; $display("FAIL reset_seg: got %h want 0000", bus.seg_out);
    end
    rst = 1'b0;
    m_lfsr = 16'hACE1;
  endtask

  task automatic test_count1;
    logic [15:0] seg, mseg;
    int lat;
    logic ab, ad;
    test_reset();
    run_op(1, 1'b0, 16'h0, seg, lat, ab, ad);
    model_run(1, mseg);
    n_tests++;
    if (seg !== 16'h0002) begin n_fail++; $display("FAIL c1_seg: got %h want 0002", seg); end
    n_tests++;
    if (lat != 2) begin n_fail++; $display("FAIL c1_lat: got %0d want 2", lat); end
    n_tests++;
    if (ab !== 1'b0 || ad !== 1'b0) begin
      n_fail++; $display("FAIL c1_after: got busy=%b done=%b want 0 0", ab, ad);
    end
    run_op(2, 1'b0, 16'h0, seg, lat, ab, ad);
    model_run(2, mseg);
    test_reset();
    run_op(2, 1'b0, 16'h0, seg, lat, ab, ad);
    model_run(2, mseg);
    n_tests++;
    if (seg !== 16'h000A) begin n_fail++; $display("FAIL c2_seg: got %h want 000a", seg); end
    n_tests++;
    if (lat != 3) begin n_fail++; $display("FAIL c2_lat: got %0d want 3", lat); end
  endtask

  task automatic test_count0;
    logic [15:0] seg;
    int lat;
    logic ab, ad;
    test_reset();
    run_op(0, 1'b0, 16'h0, seg, lat, ab, ad);
    n_tests++;
    if (seg !== 16'h0000) begin n_fail++; $display("FAIL c0_seg: got %h want 0000", seg); end
    n_tests++;
    if (lat != 1) begin n_fail++; $display("FAIL c0_lat: got %0d want 1", lat); end
    run_op(1, 1'b0, 16'h0, seg, lat, ab, ad);
    n_tests++;
    if (seg !== 16'h0002) begin
      n_fail++; $display("FAIL c0_lfsr_kept: got %h want 0002", seg);
    end
  endtask

  task automatic test_saturate;
    logic [15:0] seg;
    int lat;
    logic ab, ad;
    test_reset();
    run_op(16, 1'b0, 16'h0, seg, lat, ab, ad);
    n_tests++;
    if (seg !== 16'hFFFF) begin n_fail++; $display("FAIL c16_seg: got %h want ffff", seg); end
    n_tests++;
    if (lat != 17) begin n_fail++; $display("FAIL c16_lat: got %0d want 17", lat); end
    run_op(20, 1'b0, 16'h0, seg, lat, ab, ad);
    n_tests++;
    if (seg !== 16'hFFFF) begin n_fail++; $display("FAIL c20_seg: got %h want ffff", seg); end
    n_tests++;
    if (lat != 17) begin n_fail++; $display("FAIL c20_lat: got %0d want 17", lat); end
    repeat (3) @(negedge clk);
    n_tests++;
    if (bus.seg_out !== 16'hFFFF) begin
      n_fail++; $display("FAIL seg_hold: got %h want ffff", bus.seg_out);
    end
  endtask

  task automatic test_seed;
    logic [15:0] seg;
    int lat;
    logic ab, ad;
    test_reset();
    run_op(3, 1'b0, 16'h0, seg, lat, ab, ad);
    run_op(1, 1'b1, 16'h0000, seg, lat, ab, ad);
    n_tests++;
    if (seg !== 16'h0002) begin n_fail++; $display("FAIL seed0_seg: got %h want 0002", seg); end
    run_op(1, 1'b1, 16'h0005, seg, lat, ab, ad);
    n_tests++;
    if (seg !== 16'h0020) begin n_fail++; $display("FAIL seed5_seg: got %h want 0020", seg); end
  endtask

  task automatic test_protocol;
    logic [15:0] seg, mseg;
    int lat;
    logic ab, ad;
    int seen_done;
    test_reset();
    model_run(5, mseg);
    start_op(5, 1'b0, 16'h0);
    bus.start     = 1'b1;
    bus.load_seed = 1'b1;
    bus.seed      = 16'h1234;
    bus.count     = 5'd1;
    @(negedge clk);
    bus.start     = 1'b0;
    bus.load_seed = 1'b0;
    wait_done(2, lat);
    n_tests++;
    if (bus.seg_out !== mseg) begin
      n_fail++; $display("FAIL busy_ignore_seg: got %h want %h", bus.seg_out, mseg);
    end
    n_tests++;
    if (lat != 6) begin n_fail++; $display("FAIL busy_ignore_lat: got %0d want 6", lat); end
    @(negedge clk);
    run_op(1, 1'b0, 16'h0, seg, lat, ab, ad);
    model_run(1, mseg);
    n_tests++;
    if (seg !== mseg) begin n_fail++; $display("FAIL busy_ignore_lfsr: got %h want %h", seg, mseg); end
    start_op(8, 1'b0, 16'h0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_tests++;
    if (bus.seg_out !== 16'h0000 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst: got seg=%h busy=%b done=%b want 0000 0 0",
               bus.seg_out, bus.busy, bus.done);
    end
    seen_done = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus.done) seen_done++;
    end
    n_tests++;
    if (seen_done != 0) begin n_fail++; $display("FAIL midrst_nodone: got %0d pulses want 0", seen_done); end
    run_op(1, 1'b0, 16'h0, seg, lat, ab, ad);
    n_tests++;
    if (seg !== 16'h0002) begin n_fail++; $display("FAIL midrst_restart: got %h want 0002", seg); end
  endtask

  task automatic test_back_to_back;
    logic [15:0] seg, mseg;
    int lat;
    logic ab, ad;
    int ks [6] = '{3, 3, 7, 1, 12, 5};
    test_reset();
    for (int i = 0; i < 6; i++) begin
      run_op(ks[i], 1'b0, 16'h0, seg, lat, ab, ad);
      model_run(ks[i], mseg);
      n_tests++;
      if (seg !== mseg || lat != ks[i] + 1) begin
        n_fail++;
        $display("FAIL b2b_%0d: got seg=%h lat=%0d want seg=%h lat=%0d", i, seg, lat, mseg, ks[i] + 1);
      end
    end
  endtask

  task automatic test_random;
    logic [15:0] seg, mseg, sd;
    int lat, k, kk;
    logic ab, ad, ld;
    test_reset();
    for (int i = 0; i < 1000; i++) begin
      k  = int'($urandom_range(0, 31));
      kk = (k > 16) ? 16 : k;
      ld = 1'($urandom_range(0, 1));
      sd = ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom);
      run_op(k, ld, sd, seg, lat, ab, ad);
      model_run(k, mseg);
      n_tests++;
      if ($countones(seg) != kk) begin
        n_fail++; $display("FAIL rnd_pop_%0d: got %0d want %0d", i, $countones(seg), kk);
      end
      n_tests++;
      if (lat != kk + 1) begin
        n_fail++; $display("FAIL rnd_lat_%0d: got %0d want %0d", i, lat, kk + 1);
      end
      n_tests++;
      if (seg !== mseg) begin
        n_fail++; $display("FAIL rnd_seg_%0d: got %h want %h", i, seg, mseg);
      end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_count1();
    test_count0();
    test_saturate();
    test_seed();
    test_protocol();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
